fetch_stage: RTL



---
 rtl/fetch_stage.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage sitting directly upstream of decode. Owns the
//   program counter, issues requests to instruction memory over a
//   request/response handshake that tolerates any latency (including a
//   response in the same cycle as the request), buffers one instruction for
//   decode behind a valid/ready handshake and applies control-flow redirects,
//   discarding any wrong-path response that is still in flight.
//
// Ports
//   clk, rst_n          single clock, asynchronous active-low reset
//   redirect_i          take branch/jump this cycle (PCSrc)
//   redirect_pc_i       redirect target (low two bits ignored)
//   imem_req_o          memory request, held until imem_rvalid_i
//   imem_addr_o         request address, stable while imem_req_o is high
//   imem_rvalid_i       memory response valid
//   imem_rdata_i        memory response instruction word
//   instr_valid_o       buffered instruction valid
//   instr_ready_i       decode accepts the buffered instruction
//   instr_o             buffered instruction
//   instr_pc_o          PC of instr_o
//   instr_pc_plus4_o    instr_pc_o + 4 (jal link value)
//   op_o/funct3_o/funct7_o  fixed fields sliced from instr_o
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_pc_o,
    output logic [ADDR_WIDTH-1:0] instr_pc_plus4_o,
    output logic [6:0]            op_o,
    output logic [2:0]            funct3_o,
    output logic [6:0]            funct7_o
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    state_e                  state_r;
    logic [ADDR_WIDTH-1:0]   pc_r;
    logic [ADDR_WIDTH-1:0]   req_addr_r;
    logic                    valid_r;
    logic [DATA_WIDTH-1:0]   instr_r;
    logic [ADDR_WIDTH-1:0]   instr_pc_r;
    logic [ADDR_WIDTH-1:0]   instr_pc_plus4_r;

    logic [ADDR_WIDTH-1:0]   redirect_tgt_s;
    logic [ADDR_WIDTH-1:0]   pc_inc_s;
    logic [ADDR_WIDTH-1:0]   req_inc_s;
    logic                    req_s;
    logic [ADDR_WIDTH-1:0]   addr_s;

    // Redirect targets are word aligned; increments wrap modulo 2^ADDR_WIDTH.
    assign redirect_tgt_s = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
    assign pc_inc_s       = pc_r + PC_STEP;
    assign req_inc_s      = req_addr_r + PC_STEP;

    // Request generation. In HOLD the next request is launched in the same
    // cycle decode accepts, straight from pc, so a zero-latency memory keeps
    // one instruction per cycle flowing. A redirect suppresses that request.
    always_comb begin
        req_s  = 1'b0;
        addr_s = req_addr_r;
        case (state_r)
            ST_IDLE: begin
                req_s  = 1'b0;
                addr_s = req_addr_r;
            end
            ST_FETCH: begin
                req_s  = 1'b1;
                addr_s = req_addr_r;
            end
            ST_HOLD: begin
                req_s  = instr_ready_i & ~redirect_i;
                addr_s = pc_r;
            end
            ST_DRAIN: begin
                req_s  = 1'b1;
                addr_s = req_addr_r;
            end
            default: begin
                req_s  = 1'b0;
                addr_s = req_addr_r;
            end
        endcase
    end

    // Fetch FSM, program counter and instruction buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= ST_IDLE;
            pc_r             <= RESET_PC;
            req_addr_r       <= RESET_PC;
            valid_r          <= 1'b0;
            instr_r          <= {DATA_WIDTH{1'b0}};
            instr_pc_r       <= {ADDR_WIDTH{1'b0}};
            instr_pc_plus4_r <= PC_STEP;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Responses seen here belong to nothing and are ignored.
                    valid_r <= 1'b0;
                    state_r <= ST_FETCH;
                    if (redirect_i) begin
                        pc_r       <= redirect_tgt_s;
                        req_addr_r <= redirect_tgt_s;
                    end else begin
                        req_addr_r <= pc_r;
                    end
                end
                ST_FETCH: begin
                    if (redirect_i) begin
                        pc_r    <= redirect_tgt_s;
                        valid_r <= 1'b0;
                        if (imem_rvalid_i) begin
                            // Wrong-path data already returned: drop it and
                            // start the new request right away.
                            req_addr_r <= redirect_tgt_s;
                        end else begin
                            // Request must stay up until its response arrives.
                            state_r <= ST_DRAIN;
                        end
                    end else if (imem_rvalid_i) begin
                        instr_r          <= imem_rdata_i;
                        instr_pc_r       <= req_addr_r;
                        instr_pc_plus4_r <= req_inc_s;
                        pc_r             <= req_inc_s;
                        valid_r          <= 1'b1;
                        state_r          <= ST_HOLD;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_HOLD: begin
                    if (redirect_i) begin
                        pc_r       <= redirect_tgt_s;
                        req_addr_r <= redirect_tgt_s;
                        valid_r    <= 1'b0;
                        state_r    <= ST_FETCH;
                    end else if (instr_ready_i) begin
                        if (imem_rvalid_i) begin
                            instr_r          <= imem_rdata_i;
                            instr_pc_r       <= pc_r;
                            instr_pc_plus4_r <= pc_inc_s;
                            pc_r             <= pc_inc_s;
                            req_addr_r       <= pc_inc_s;
                            valid_r          <= 1'b1;
                            state_r          <= ST_HOLD;
                        end else begin
                            // Request launched from pc stays up in FETCH.
                            valid_r    <= 1'b0;
                            req_addr_r <= pc_r;
                            state_r    <= ST_FETCH;
                        end
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                ST_DRAIN: begin
                    if (redirect_i) begin
                        pc_r <= redirect_tgt_s;
                    end else begin
                        pc_r <= pc_r;
                    end
                    if (imem_rvalid_i) begin
                        // Stale response discarded; fetch the current pc.
                        req_addr_r <= redirect_i ? redirect_tgt_s : pc_r;
                        state_r    <= ST_FETCH;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_o       = req_s;
    assign imem_addr_o      = addr_s;
    assign instr_valid_o    = valid_r;
    assign instr_o          = instr_r;
    assign instr_pc_o       = instr_pc_r;
    assign instr_pc_plus4_o = instr_pc_plus4_r;
    assign op_o             = instr_r[6:0];
    assign funct3_o         = instr_r[14:12];
    assign funct7_o         = instr_r[31:25];

endmodule
